// File: rtl/tilemap_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tilemap_arbiter_pkg
// Shared definitions for the tilemap RAM arbiter: maze geometry, FSM state
// encodings and small helpers used by the arbiter and its round-robin picker.
// -----------------------------------------------------------------------------
package tilemap_arbiter_pkg;

  // Maze geometry (tiles). The tile count bounds the legal RAM index range.
  localparam int TILE_ROW_NUM   = 31;
  localparam int TILE_COL_NUM   = 28;
  localparam int TILE_COUNT_DEF = TILE_ROW_NUM * TILE_COL_NUM;

  // Read data returned for an out-of-range tile: behaves like a solid wall.
  localparam logic [1:0] RDATA_WALL = 2'b10;

  typedef enum logic [2:0] {
    TARB_IDLE   = 3'd0,
    TARB_ISSUE  = 3'd1,
    TARB_WAIT   = 3'd2,
    TARB_RMW_WR = 3'd3,
    TARB_DONE   = 3'd4
  } tarb_state_e;

  // Round-robin pointer after serving 'owner': next requester, wrapping back
  // to 1 because requester 0 never takes part in the rotation.
  function automatic int rr_wrap_next(input int owner, input int num_req);
    if (owner >= num_req - 1) return 1;
    else return owner + 1;
  endfunction

endpackage

// File: rtl/tilemap_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// tilemap_arbiter_rr_pick
// Combinational round-robin picker over requesters 1..NUM_REQ-1.
// Ports:
//   i_req   [NUM_REQ-2:0]  requests of requesters 1..NUM_REQ-1 (bit k = req k+1)
//   i_ptr   [PTR_W-1:0]    requester number with highest priority (1..NUM_REQ-1)
//   o_grant [NUM_REQ-2:0]  one-hot grant, same bit mapping as i_req
//   o_valid                at least one request present
// -----------------------------------------------------------------------------
module tilemap_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-2:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-2:0] o_grant,
  output logic               o_valid
);

  // First pass scans ptr..NUM_REQ-1, second pass picks up the wrapped part
  // (1..ptr-1); anything above ptr was already rejected in the first pass.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!o_valid && i_req[j-1] && (j >= int'(i_ptr))) begin
        o_grant[j-1] = 1'b1;
        o_valid      = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
    for (int j = 1; j < NUM_REQ; j++) begin
      if (!o_valid && i_req[j-1]) begin
        o_grant[j-1] = 1'b1;
        o_valid      = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/tilemap_arbiter.sv
// -----------------------------------------------------------------------------
// tilemap_arbiter
// Shares the single-port tilemap RAM ({wall,dot} per tile) among NUM_REQ
// requesters. Requester 0 (renderer) has fixed top priority, limited by a
// starvation counter; requesters 1..NUM_REQ-1 rotate round-robin. One
// transaction in flight, 1-cycle RAM read latency. All outputs registered.
// Ports:
//   clk, reset (async, active-low)
//   req/we/wdata [NUM_REQ]   per-requester request, write flag, dot value
//   idx [NUM_REQ*IDX_W]      per-requester tile index (slice i = requester i)
//   ack [NUM_REQ]            1-cycle completion pulse to the owner
//   rdata [2]                {wall,dot}, valid with ack
//   mem_en/mem_we/mem_idx/mem_wdata  RAM command; mem_rdata [2] RAM read data
// Configuration macro: TILEMAP_ARB_RMW_EN -- reads with wdata=0 atomically
//   clear the dot they return (consume), via an extra RMW_WR state.
// -----------------------------------------------------------------------------
module tilemap_arbiter
  import tilemap_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 10,
  parameter int TILE_COUNT   = TILE_COUNT_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [NUM_REQ*IDX_W-1:0] idx,
  input  logic [NUM_REQ-1:0]       wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [1:0]               rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [IDX_W-1:0]         mem_idx,
  output logic                     mem_wdata,
  input  logic [1:0]               mem_rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W:0]   TILE_LIM   = (IDX_W+1)'(TILE_COUNT);

  tarb_state_e r_state;
  tarb_state_e w_next_state;

  logic [PTR_W-1:0]   r_owner;
  logic               r_we;
  logic               r_oob;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_starve;
`ifdef TILEMAP_ARB_RMW_EN
  logic [IDX_W-1:0]   r_idx;
  logic               r_wdata;
  logic [1:0]         r_cap;
`endif

  logic [NUM_REQ-2:0] w_rr_grant;
  logic               w_rr_valid;
  logic [PTR_W-1:0]   w_rr_owner;
  logic               w_force_rr;
  logic [PTR_W-1:0]   w_owner;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_we;
  logic               w_sel_wdata;
  logic               w_sel_oob;

  tilemap_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req   (req[NUM_REQ-1:1]),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_valid (w_rr_valid)
  );

  // Owner selection: renderer wins unless it is idle or an RR requester has
  // waited through STARVE_LIMIT consecutive renderer grants.
  always_comb begin
    w_rr_owner = '0;
    for (int j = 1; j < NUM_REQ; j++) begin
      if (w_rr_grant[j-1]) w_rr_owner = PTR_W'(j);
      else w_rr_owner = w_rr_owner;
    end
    w_force_rr = w_rr_valid && (!req[0] || (r_starve == STARVE_MAX));
    if (w_force_rr) w_owner = w_rr_owner;
    else w_owner = '0;
    w_sel_idx   = idx[int'(w_owner)*IDX_W +: IDX_W];
    w_sel_we    = we[w_owner];
    w_sel_wdata = wdata[w_owner];
    w_sel_oob   = ({1'b0, w_sel_idx} >= TILE_LIM);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= TARB_IDLE;
    else r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      TARB_IDLE: begin
        if (|req) w_next_state = TARB_ISSUE;
        else w_next_state = TARB_IDLE;
      end
      TARB_ISSUE: begin
        // Writes and out-of-range accesses have no read data to wait for.
        if (r_oob || r_we) w_next_state = TARB_DONE;
        else w_next_state = TARB_WAIT;
      end
      TARB_WAIT: begin
`ifdef TILEMAP_ARB_RMW_EN
        // Consume: a wdata=0 read that found a dot clears it before acking.
        if (!r_wdata && mem_rdata[0]) w_next_state = TARB_RMW_WR;
        else w_next_state = TARB_DONE;
`else
        w_next_state = TARB_DONE;
`endif
      end
      TARB_RMW_WR: w_next_state = TARB_DONE;
      TARB_DONE:   w_next_state = TARB_IDLE;
      default:     w_next_state = TARB_IDLE;
    endcase
  end

  // Grant bookkeeping: latch the transaction, advance RR pointer and starve counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner  <= '0;
      r_we     <= 1'b0;
      r_oob    <= 1'b0;
      r_rr_ptr <= PTR_W'(1);
      r_starve <= '0;
    end else if (r_state == TARB_IDLE && |req) begin
      r_owner <= w_owner;
      r_we    <= w_sel_we;
      r_oob   <= w_sel_oob;
      if (w_force_rr) begin
        r_rr_ptr <= PTR_W'(rr_wrap_next(int'(w_rr_owner), NUM_REQ));
        r_starve <= '0;
      end else if (w_rr_valid) begin
        if (r_starve != STARVE_MAX) r_starve <= r_starve + CNT_W'(1);
        else r_starve <= r_starve;
      end else begin
        r_starve <= '0;
      end
    end else begin
      r_owner <= r_owner;
    end
  end

`ifdef TILEMAP_ARB_RMW_EN
  // Consume path: keep index/wdata for the clear and the pre-clear read value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_wdata <= 1'b0;
      r_cap   <= 2'b00;
    end else begin
      if (r_state == TARB_IDLE && |req) begin
        r_idx   <= w_sel_idx;
        r_wdata <= w_sel_wdata;
      end else begin
        r_idx <= r_idx;
      end
      if (r_state == TARB_WAIT) r_cap <= mem_rdata;
      else r_cap <= r_cap;
    end
  end
`endif

  // Registered outputs, decoded from the state being entered so they are
  // valid for exactly the cycle spent in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack       <= '0;
      rdata     <= 2'b00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_idx   <= '0;
      mem_wdata <= 1'b0;
    end else begin
      ack       <= '0;
      rdata     <= 2'b00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_idx   <= '0;
      mem_wdata <= 1'b0;
      case (w_next_state)
        TARB_ISSUE: begin
          // ISSUE is only entered from IDLE, so the live selection applies.
          if (!w_sel_oob) begin
            mem_en    <= 1'b1;
            mem_we    <= w_sel_we;
            mem_idx   <= w_sel_idx;
            mem_wdata <= w_sel_wdata;
          end else begin
            mem_en <= 1'b0;
          end
        end
`ifdef TILEMAP_ARB_RMW_EN
        TARB_RMW_WR: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_idx   <= r_idx;
          mem_wdata <= 1'b0;
        end
`endif
        TARB_DONE: begin
          ack[r_owner] <= 1'b1;
          if (r_state == TARB_WAIT) rdata <= mem_rdata;
`ifdef TILEMAP_ARB_RMW_EN
          else if (r_state == TARB_RMW_WR) rdata <= r_cap;
`endif
          else if (r_oob) rdata <= RDATA_WALL;
          else rdata <= 2'b00;
        end
        default: begin
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tilemap_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tilemap_arbiter
// Self-checking bench: a behavioural RAM, requester driver and an ack
// scoreboard (expected owner/rdata queued at stimulus time, popped on ack).
// -----------------------------------------------------------------------------
module tb_tilemap_arbiter;
  import tilemap_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 10;
  localparam int TC      = TILE_COUNT_DEF;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ-1:0]       we = '0;
  logic [NUM_REQ*IDX_W-1:0] idx = '0;
  logic [NUM_REQ-1:0]       wdata = '0;
  logic [NUM_REQ-1:0]       ack;
  logic [1:0]               rdata;
  logic                     mem_en;
  logic                     mem_we;
  logic [IDX_W-1:0]         mem_idx;
  logic                     mem_wdata;
  logic [1:0]               mem_rdata = 2'b00;

  tilemap_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .IDX_W        (IDX_W),
    .TILE_COUNT   (TC),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .idx       (idx),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_idx   (mem_idx),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int mem_en_cnt = 0;
  int mem_wr_cnt = 0;
  int ack_cnt    = 0;
  int left [NUM_REQ];

  typedef struct {
    int         owner;
    logic [1:0] rdata;
  } exp_t;
  exp_t sb [$];

  logic [1:0] ram [0:1023];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural single-port RAM, 1-cycle read latency, dot-bit writes
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_idx][0] <= mem_wdata;
      else mem_rdata <= ram[mem_idx];
    end
  end

  // Monitor: count RAM activity, compare every ack against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (mem_en) mem_en_cnt++;
      if (mem_en && mem_we) mem_wr_cnt++;
      if (ack != '0) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          check_val("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("ack_owner", 32'(ack), 32'd1 << e.owner);
          check_val("ack_rdata", 32'(rdata), 32'(e.rdata));
        end
      end
    end
  end

  task automatic push_exp(input int owner, input logic [1:0] rd);
    exp_t e;
    e.owner = owner;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    we    = '0;
    wdata = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) left[i] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic set_req(input int r, input logic w, input int ix, input logic wd);
    we[r]                   = w;
    idx[r*IDX_W +: IDX_W]   = IDX_W'(ix);
    wdata[r]                = wd;
    req[r]                  = 1'b1;
  endtask

  // Hold requests until each requester has received its quota of acks
  task automatic run_reqs(input int budget);
    int cyc;
    int rem;
    cyc = 0;
    rem = left[0] + left[1] + left[2] + left[3];
    while (rem > 0 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) req[i] = 1'b0;
        end
      end
      rem = left[0] + left[1] + left[2] + left[3];
    end
    check_val("acks_within_budget", 32'(rem), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 2'b00;

    // Reset state
    #2;
    check_val("reset_outputs", {26'd0, ack, rdata}, 32'd0);
    check_val("reset_mem", {20'd0, mem_en, mem_we, mem_idx}, 32'd0);
    do_reset();

    // Single read by requester 2: mem_en in cycle 1, ack in cycle 3
    ram[5] = 2'b01;
    push_exp(2, 2'b01);
    set_req(2, 1'b0, 5, 1'b1);
    @(posedge clk); #1;
    check_val("rd_mem_en_c1", 32'(mem_en), 32'd1);
    check_val("rd_mem_idx_c1", 32'(mem_idx), 32'd5);
    check_val("rd_mem_we_c1", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check_val("rd_ack_c2", 32'(ack), 32'd0);
    check_val("rd_mem_en_c2", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    check_val("rd_ack_c3", 32'(ack), 32'b0100);
    check_val("rd_rdata_c3", 32'(rdata), 32'b01);
    req[2] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single write by requester 1: ack in cycle 2, rdata 0, dot updated
    ram[9] = 2'b10;
    push_exp(1, 2'b00);
    set_req(1, 1'b1, 9, 1'b1);
    @(posedge clk); #1;
    check_val("wr_mem_cmd_c1", {29'd0, mem_en, mem_we, mem_wdata}, 32'b111);
    @(posedge clk); #1;
    check_val("wr_ack_c2", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    @(posedge clk); #1;
    check_val("wr_ram9", 32'(ram[9]), 32'b11);

    // Round-robin 1,2,3 then wrap back to 1
    do_reset();
    ram[1] = 2'b00; ram[2] = 2'b11; ram[3] = 2'b10;
    push_exp(1, 2'b00); push_exp(2, 2'b11); push_exp(3, 2'b10); push_exp(1, 2'b00);
    left[1] = 2; left[2] = 1; left[3] = 1;
    set_req(1, 1'b0, 1, 1'b1);
    set_req(2, 1'b0, 2, 1'b1);
    set_req(3, 1'b0, 3, 1'b1);
    run_reqs(60);

    // Starvation: 8 renderer grants, then requester 1, then renderer again
    do_reset();
    ram[4] = 2'b01; ram[6] = 2'b11;
    for (int i = 0; i < 8; i++) push_exp(0, 2'b01);
    push_exp(1, 2'b11);
    push_exp(0, 2'b01);
    left[0] = 9; left[1] = 1;
    set_req(0, 1'b0, 4, 1'b1);
    set_req(1, 1'b0, 6, 1'b1);
    run_reqs(120);

    // Index range boundaries
    do_reset();
    mem_en_cnt = 0;
    push_exp(3, 2'b10);
    left[3] = 1;
    set_req(3, 1'b0, TC, 1'b1);
    run_reqs(20);
    check_val("oob_rd_no_mem_en", 32'(mem_en_cnt), 32'd0);
    ram[TC-1] = 2'b11;
    push_exp(3, 2'b11);
    left[3] = 1;
    set_req(3, 1'b0, TC - 1, 1'b1);
    run_reqs(20);
    check_val("last_tile_mem_en", 32'(mem_en_cnt), 32'd1);
    push_exp(1, 2'b10);
    left[1] = 1;
    set_req(1, 1'b1, 1023, 1'b1);
    run_reqs(20);
    check_val("oob_wr_no_mem_en", 32'(mem_en_cnt), 32'd1);

    // Reset mid-transaction (in ISSUE, then in WAIT): outputs clear, no ack later
    for (int d = 1; d <= 2; d++) begin
      int acks_before;
      do_reset();
      set_req(2, 1'b0, 5, 1'b1);
      repeat (d) @(posedge clk);
      #1;
      reset = 1'b0;
      req   = '0;
      #1;
      check_val("rst_mid_outputs", {26'd0, ack, rdata}, 32'd0);
      check_val("rst_mid_mem", {19'd0, mem_en, mem_we, mem_wdata, mem_idx}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      acks_before = ack_cnt;
      repeat (6) @(posedge clk);
      #1;
      check_val("rst_mid_no_ack", 32'(ack_cnt), 32'(acks_before));
    end

`ifdef TILEMAP_ARB_RMW_EN
    // Consume reads: first returns the dot and clears it, second sees it gone
    do_reset();
    ram[7] = 2'b01;
    mem_wr_cnt = 0;
    push_exp(1, 2'b01);
    left[1] = 1;
    set_req(1, 1'b0, 7, 1'b0);
    run_reqs(20);
    push_exp(2, 2'b00);
    left[2] = 1;
    set_req(2, 1'b0, 7, 1'b0);
    run_reqs(20);
    check_val("rmw_one_write", 32'(mem_wr_cnt), 32'd1);
    check_val("rmw_ram7", 32'(ram[7]), 32'b00);
`endif

    check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
